z_axil_gpio_timer: RTL and testbench

- AXI4-Lite responder (slave) holding a small MMIO register file: GPIO output, synchronised GPIO input, a 32-bit free-running timer with compare match, and an interrupt line.
- Sits on the core's AXI4-Lite bus beside z_axi_mem_if, reached through an address-decoded port.
- Gives z_core_control_u its first memory-mapped I/O target.

---
 rtl/z_axil_gpio_timer_pkg.sv | 37 +++
 rtl/z_axil_gpio_timer_if.sv | 38 +++
 rtl/z_axil_gpio_timer_slave_if.sv | 106 ++++++++++
 rtl/z_axil_gpio_timer.sv | 137 +++++++++++++
 tb/tb_z_axil_gpio_timer.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/z_axil_gpio_timer_pkg.sv
// Shared constants and helpers for the AXI4-Lite GPIO/timer block.
package z_axil_pkg;

   localparam int unsigned REG_WIDTH = 32;
   localparam int unsigned OFF_WIDTH = 5;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [OFF_WIDTH-1:0] OFF_GPIO_OUT  = 5'h00;
   localparam logic [OFF_WIDTH-1:0] OFF_GPIO_IN   = 5'h04;
   localparam logic [OFF_WIDTH-1:0] OFF_TIMER_CNT = 5'h08;
   localparam logic [OFF_WIDTH-1:0] OFF_TIMER_CMP = 5'h0C;
   localparam logic [OFF_WIDTH-1:0] OFF_STATUS    = 5'h10;
   localparam logic [OFF_WIDTH-1:0] OFF_CTRL      = 5'h14;
   // First unmapped offset; everything from here up answers SLVERR.
   localparam logic [OFF_WIDTH-1:0] OFF_RSVD      = 5'h18;

   localparam int unsigned STATUS_MATCH_BIT = 0;
   localparam int unsigned CTRL_TMR_EN_BIT  = 0;
   localparam int unsigned CTRL_IRQ_EN_BIT  = 1;

   // Merge write data into a 32-bit register value under byte enables.
   function automatic logic [REG_WIDTH-1:0] apply_strb(
      input logic [REG_WIDTH-1:0]   cur,
      input logic [REG_WIDTH-1:0]   nxt,
      input logic [REG_WIDTH/8-1:0] strb
   );
      logic [REG_WIDTH-1:0] res;
      res = cur;
      for (int i = 0; i < int'(REG_WIDTH / 8); i++) begin
         if (strb[i]) res[8*i +: 8] = nxt[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/z_axil_gpio_timer_if.sv
// AXI4-Lite bus bundle between the core-side master and this responder.
interface z_axil_gpio_timer_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) ();
   logic [ADDR_WIDTH-1:0] aw_addr;
   logic [2:0]            aw_prot;
   logic                  aw_valid;
   logic                  aw_ready;
   logic [DATA_WIDTH-1:0] w_data;
   logic [STRB_WIDTH-1:0] w_strb;
   logic                  w_valid;
   logic                  w_ready;
   logic [1:0]            b_resp;
   logic                  b_valid;
   logic                  b_ready;
   logic [ADDR_WIDTH-1:0] ar_addr;
   logic [2:0]            ar_prot;
   logic                  ar_valid;
   logic                  ar_ready;
   logic [DATA_WIDTH-1:0] r_data;
   logic [1:0]            r_resp;
   logic                  r_valid;
   logic                  r_ready;

   modport master (
      output aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready,
             ar_addr, ar_prot, ar_valid, r_ready,
      input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
   );

   modport slave (
      input  aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready,
             ar_addr, ar_prot, ar_valid, r_ready,
      output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
   );
endinterface

// File: rtl/z_axil_gpio_timer_slave_if.sv
// AXI4-Lite responder front end: AW/W holding, B/R response registers,
// and a flat single-cycle register access port toward the register file.
module z_axil_slave_if
   import z_axil_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   z_axil_gpio_timer_if.slave    bus,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic [STRB_WIDTH-1:0] wr_strb,
   input  logic                  wr_err,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  rd_err
);

   logic                  aw_held;
   logic                  w_held;
   logic [ADDR_WIDTH-1:0] aw_addr_q;
   logic [DATA_WIDTH-1:0] w_data_q;
   logic [STRB_WIDTH-1:0] w_strb_q;
   logic                  b_valid_q;
   logic [1:0]            b_resp_q;
   logic                  r_valid_q;
   logic [DATA_WIDTH-1:0] r_data_q;
   logic [1:0]            r_resp_q;

   logic aw_hs;
   logic w_hs;
   logic unused_prot;

   assign unused_prot = ^{bus.aw_prot, bus.ar_prot};

   assign bus.aw_ready = !aw_held && !b_valid_q;
   assign bus.w_ready  = !w_held && !b_valid_q;
   assign bus.b_valid  = b_valid_q;
   assign bus.b_resp   = b_resp_q;
   assign bus.ar_ready = !r_valid_q;
   assign bus.r_valid  = r_valid_q;
   assign bus.r_data   = r_data_q;
   assign bus.r_resp   = r_resp_q;

   assign aw_hs = bus.aw_valid && bus.aw_ready;
   assign w_hs  = bus.w_valid && bus.w_ready;

   // Commit once address and data are both present, held or arriving now.
   assign wr_en   = (aw_held || aw_hs) && (w_held || w_hs);
   assign wr_addr = aw_held ? aw_addr_q : bus.aw_addr;
   assign wr_data = w_held ? w_data_q : bus.w_data;
   assign wr_strb = w_held ? w_strb_q : bus.w_strb;

   assign rd_en   = bus.ar_valid && !r_valid_q;
   assign rd_addr = bus.ar_addr;

   // Write path: hold AW/W independently, raise B on commit until accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         b_valid_q <= 1'b0;
         b_resp_q  <= RESP_OKAY;
      end else begin
         if (aw_hs) aw_addr_q <= bus.aw_addr;
         if (w_hs) begin
            w_data_q <= bus.w_data;
            w_strb_q <= bus.w_strb;
         end
         if (b_valid_q && bus.b_ready) b_valid_q <= 1'b0;
         if (wr_en) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            b_valid_q <= 1'b1;
            b_resp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
         end else begin
            if (aw_hs) aw_held <= 1'b1;
            if (w_hs) w_held <= 1'b1;
         end
      end
   end

   // Read path: capture register data on AR handshake, hold until accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid_q <= 1'b0;
         r_data_q  <= '0;
         r_resp_q  <= RESP_OKAY;
      end else if (rd_en) begin
         r_valid_q <= 1'b1;
         r_data_q  <= rd_err ? '0 : rd_data;
         r_resp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (r_valid_q && bus.r_ready) begin
         r_valid_q <= 1'b0;
      end
   end

endmodule

// File: rtl/z_axil_gpio_timer.sv
// MMIO peripheral: GPIO out/in, free-running 32-bit timer with compare
// match, and a level interrupt, behind an AXI4-Lite responder.
module z_axil_gpio_timer
   import z_axil_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
   parameter int unsigned GPIO_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   z_axil_gpio_timer_if.slave    bus,
   input  logic [GPIO_WIDTH-1:0] gpio_in,
   output logic [GPIO_WIDTH-1:0] gpio_out,
   output logic                  irq
);

   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [STRB_WIDTH-1:0] wr_strb;
   logic                  wr_err;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_err;

   logic [GPIO_WIDTH-1:0] gpio_q;
   logic [GPIO_WIDTH-1:0] gpio_s1;
   logic [GPIO_WIDTH-1:0] gpio_s2;
   logic [REG_WIDTH-1:0]  cnt;
   logic [REG_WIDTH-1:0]  cmp;
   logic                  match;
   logic                  tmr_en;
   logic                  irq_en;

   logic [OFF_WIDTH-1:0]  wr_off;
   logic [OFF_WIDTH-1:0]  rd_off;
   logic [REG_WIDTH-1:0]  ctrl_cur;
   logic [REG_WIDTH-1:0]  gpio_merged;
   logic [REG_WIDTH-1:0]  cnt_merged;
   logic [REG_WIDTH-1:0]  cmp_merged;
   logic [REG_WIDTH-1:0]  ctrl_merged;
   logic                  match_clr;
   logic                  unused_bits;

   z_axil_slave_if #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .STRB_WIDTH (STRB_WIDTH)
   ) u_slave (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .wr_strb (wr_strb),
      .wr_err  (wr_err),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .rd_err  (rd_err)
   );

   // Word offsets: only addr[4:2] select a register.
   assign wr_off = {wr_addr[4:2], 2'b00};
   assign rd_off = {rd_addr[4:2], 2'b00};
   assign wr_err = (wr_off >= OFF_RSVD);
   assign rd_err = (rd_off >= OFF_RSVD);

   assign gpio_out = gpio_q;
   assign irq      = match && irq_en;

   assign unused_bits = ^{wr_addr, rd_addr, rd_en, ctrl_merged};

   // Byte-merged next values for each writable register.
   always_comb begin
      ctrl_cur                  = '0;
      ctrl_cur[CTRL_TMR_EN_BIT] = tmr_en;
      ctrl_cur[CTRL_IRQ_EN_BIT] = irq_en;
      gpio_merged = apply_strb(REG_WIDTH'(gpio_q), REG_WIDTH'(wr_data), wr_strb);
      cnt_merged  = apply_strb(cnt, REG_WIDTH'(wr_data), wr_strb);
      cmp_merged  = apply_strb(cmp, REG_WIDTH'(wr_data), wr_strb);
      ctrl_merged = apply_strb(ctrl_cur, REG_WIDTH'(wr_data), wr_strb);
      match_clr   = wr_en && (wr_off == OFF_STATUS) && wr_strb[0] &&
                    wr_data[STATUS_MATCH_BIT];
   end

   // Read mux over current register state (pre-commit values).
   always_comb begin
      rd_data = '0;
      case (rd_off)
         OFF_GPIO_OUT:  rd_data = DATA_WIDTH'(gpio_q);
         OFF_GPIO_IN:   rd_data = DATA_WIDTH'(gpio_s2);
         OFF_TIMER_CNT: rd_data = DATA_WIDTH'(cnt);
         OFF_TIMER_CMP: rd_data = DATA_WIDTH'(cmp);
         OFF_STATUS:    rd_data[STATUS_MATCH_BIT] = match;
         OFF_CTRL:      rd_data = DATA_WIDTH'(ctrl_cur);
         default:       rd_data = '0;
      endcase
   end

   // Register file, input synchroniser and timer.
   always_ff @(posedge clk) begin
      if (rst) begin
         gpio_q  <= '0;
         gpio_s1 <= '0;
         gpio_s2 <= '0;
         cnt     <= '0;
         cmp     <= '0;
         match   <= 1'b0;
         tmr_en  <= 1'b0;
         irq_en  <= 1'b0;
      end else begin
         gpio_s1 <= gpio_in;
         gpio_s2 <= gpio_s1;

         if (wr_en && (wr_off == OFF_GPIO_OUT)) gpio_q <= GPIO_WIDTH'(gpio_merged);
         if (wr_en && (wr_off == OFF_TIMER_CMP)) cmp <= cmp_merged;

         if (wr_en && (wr_off == OFF_TIMER_CNT)) cnt <= cnt_merged;
         else if (tmr_en) cnt <= cnt + REG_WIDTH'(1);

         // A new match outranks a simultaneous W1C.
         if (tmr_en && (cnt == cmp)) match <= 1'b1;
         else if (match_clr) match <= 1'b0;

         if (wr_en && (wr_off == OFF_CTRL)) begin
            tmr_en <= ctrl_merged[CTRL_TMR_EN_BIT];
            irq_en <= ctrl_merged[CTRL_IRQ_EN_BIT];
         end
      end
   end

endmodule

// File: tb/tb_z_axil_gpio_timer.sv
// Directed bench for z_axil_gpio_timer: bus handshakes, register map,
// timer match/W1C interplay, decode errors, synchroniser and mid-flight reset.
module tb_z_axil_gpio_timer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] gpio_in = 8'h00;
   logic [7:0] gpio_out;
   logic       irq;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;

   z_axil_gpio_timer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   z_axil_gpio_timer #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (32),
      .GPIO_WIDTH (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .gpio_in  (gpio_in),
      .gpio_out (gpio_out),
      .irq      (irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full write; returns response and the cycle index of the commit edge.
   task automatic axil_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp,
                             output int ecyc);
      bit aw_d = 1'b0;
      bit w_d  = 1'b0;
      bit ahs;
      bit whs;
      int n = 0;
      bus.aw_addr  = addr;
      bus.aw_valid = 1'b1;
      bus.w_data   = data;
      bus.w_strb   = strb;
      bus.w_valid  = 1'b1;
      bus.b_ready  = 1'b1;
      while (!(aw_d && w_d) && n < 20) begin
         ahs = bus.aw_valid && bus.aw_ready;
         whs = bus.w_valid && bus.w_ready;
         tick();
         n++;
         if (ahs) begin aw_d = 1'b1; bus.aw_valid = 1'b0; end
         if (whs) begin w_d = 1'b1; bus.w_valid = 1'b0; end
      end
      n = 0;
      while (!bus.b_valid && n < 20) begin tick(); n++; end
      checks++;
      if (!bus.b_valid) begin
         errors++;
         $display("FAIL write_timeout addr=%h got b_valid=%b want 1", addr, bus.b_valid);
         bus.aw_valid = 1'b0;
         bus.w_valid  = 1'b0;
         resp = 2'bxx;
         ecyc = cyc;
      end else begin
         resp = bus.b_resp;
         ecyc = cyc;
         tick();
      end
   endtask

   // Full read; checks the one-cycle AR-to-R latency on the way.
   task automatic axil_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
      int n = 0;
      bus.ar_addr  = addr;
      bus.ar_valid = 1'b1;
      bus.r_ready  = 1'b1;
      while (!bus.ar_ready && n < 20) begin tick(); n++; end
      tick();
      bus.ar_valid = 1'b0;
      checks++;
      if (bus.r_valid !== 1'b1) begin
         errors++;
         $display("FAIL read_latency addr=%h got r_valid=%b want 1", addr, bus.r_valid);
         data = 32'hxxxxxxxx;
         resp = 2'bxx;
      end else begin
         data = bus.r_data;
         resp = bus.r_resp;
         tick();
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic [1:0]  r;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      checks += 8;
      if (bus.aw_ready !== 1'b1) begin errors++; $display("FAIL rst_aw_ready got %b want 1", bus.aw_ready); end
      if (bus.w_ready !== 1'b1) begin errors++; $display("FAIL rst_w_ready got %b want 1", bus.w_ready); end
      if (bus.ar_ready !== 1'b1) begin errors++; $display("FAIL rst_ar_ready got %b want 1", bus.ar_ready); end
      if (bus.b_valid !== 1'b0) begin errors++; $display("FAIL rst_b_valid got %b want 0", bus.b_valid); end
      if (bus.r_valid !== 1'b0) begin errors++; $display("FAIL rst_r_valid got %b want 0", bus.r_valid); end
      if (bus.r_data !== 32'h0) begin errors++; $display("FAIL rst_r_data got %h want 0", bus.r_data); end
      if (gpio_out !== 8'h00) begin errors++; $display("FAIL rst_gpio_out got %h want 00", gpio_out); end
      if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b want 0", irq); end
      axil_read(32'h14, d, r);
      checks += 2;
      if (d !== 32'h0) begin errors++; $display("FAIL rst_ctrl_data got %h want 0", d); end
      if (r !== 2'b00) begin errors++; $display("FAIL rst_ctrl_resp got %b want 00", r); end
   endtask

   task automatic test_w_before_aw();
      bus.b_ready = 1'b0;
      bus.w_data  = 32'h000000A5;
      bus.w_strb  = 4'b0001;
      bus.w_valid = 1'b1;
      tick();
      bus.w_valid = 1'b0;
      checks += 2;
      if (bus.w_ready !== 1'b0) begin errors++; $display("FAIL wfirst_w_held got w_ready=%b want 0", bus.w_ready); end
      if (bus.b_valid !== 1'b0) begin errors++; $display("FAIL wfirst_no_b got %b want 0", bus.b_valid); end
      tick(); tick();
      bus.aw_addr  = 32'h00;
      bus.aw_valid = 1'b1;
      tick();
      bus.aw_valid = 1'b0;
      checks += 3;
      if (bus.b_valid !== 1'b1) begin errors++; $display("FAIL wfirst_b_valid got %b want 1", bus.b_valid); end
      if (bus.b_resp !== 2'b00) begin errors++; $display("FAIL wfirst_b_resp got %b want 00", bus.b_resp); end
      if (gpio_out !== 8'hA5) begin errors++; $display("FAIL wfirst_gpio_out got %h want a5", gpio_out); end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks += 3;
         if (bus.b_valid !== 1'b1) begin errors++; $display("FAIL bhold_b_valid cyc%0d got %b want 1", i, bus.b_valid); end
         if (bus.aw_ready !== 1'b0) begin errors++; $display("FAIL bhold_aw_ready cyc%0d got %b want 0", i, bus.aw_ready); end
         if (bus.w_ready !== 1'b0) begin errors++; $display("FAIL bhold_w_ready cyc%0d got %b want 0", i, bus.w_ready); end
      end
      bus.b_ready = 1'b1;
      tick();
      checks += 2;
      if (bus.b_valid !== 1'b0) begin errors++; $display("FAIL bdone_b_valid got %b want 0", bus.b_valid); end
      if (bus.aw_ready !== 1'b1) begin errors++; $display("FAIL bdone_aw_ready got %b want 1", bus.aw_ready); end
   endtask

   task automatic test_timer_match();
      logic [1:0]  r;
      logic [31:0] d;
      int e;
      axil_write(32'h0C, 32'd10, 4'hF, r, e);
      axil_write(32'h08, 32'd0, 4'hF, r, e);
      axil_write(32'h14, 32'd3, 4'hF, r, e);
      // Count is 10 after edge e+10; match is set at edge e+11.
      while (cyc < e + 10) tick();
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL match_early got irq=%b want 0", irq); end
      tick();
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL match_irq got irq=%b want 1", irq); end
      axil_read(32'h10, d, r);
      checks++;
      if (d !== 32'h1) begin errors++; $display("FAIL match_status got %h want 1", d); end
   endtask

   task automatic test_w1c();
      logic [1:0]  r;
      logic [31:0] d;
      int e;
      int e2;
      axil_write(32'h10, 32'h1, 4'h1, r, e);
      checks += 2;
      if (irq !== 1'b0) begin errors++; $display("FAIL w1c_clear_irq got %b want 0", irq); end
      axil_read(32'h10, d, r);
      if (d !== 32'h0) begin errors++; $display("FAIL w1c_clear_status got %h want 0", d); end
      axil_write(32'h0C, 32'd1000, 4'hF, r, e);
      axil_write(32'h08, 32'd997, 4'hF, r, e);
      // Count reaches 1000 after edge e+3, so the match sets at edge e+4.
      while (cyc < e + 3) tick();
      axil_write(32'h10, 32'h1, 4'h1, r, e2);
      checks += 3;
      if (e2 != e + 4) begin errors++; $display("FAIL w1c_commit_edge got %0d want %0d", e2 - e, 4); end
      if (irq !== 1'b1) begin errors++; $display("FAIL w1c_collide_irq got %b want 1", irq); end
      axil_read(32'h10, d, r);
      if (d !== 32'h1) begin errors++; $display("FAIL w1c_collide_status got %h want 1", d); end
      axil_write(32'h10, 32'h1, 4'h1, r, e);
      checks += 2;
      if (irq !== 1'b0) begin errors++; $display("FAIL w1c_repeat_irq got %b want 0", irq); end
      axil_read(32'h10, d, r);
      if (d !== 32'h0) begin errors++; $display("FAIL w1c_repeat_status got %h want 0", d); end
   endtask

   task automatic test_wrap();
      logic [1:0]  r;
      logic [31:0] d;
      logic [31:0] exp;
      int e1;
      int e2;
      axil_write(32'h14, 32'h0, 4'hF, r, e1);
      axil_write(32'h08, 32'hFFFFFFFD, 4'hF, r, e1);
      axil_write(32'h14, 32'h1, 4'hF, r, e1);
      tick(); tick(); tick();
      axil_write(32'h14, 32'h0, 4'hF, r, e2);
      // Running from edge e1+1 through edge e2 inclusive.
      exp = 32'hFFFFFFFD + 32'(e2 - e1);
      axil_read(32'h08, d, r);
      checks += 2;
      if (e2 - e1 != 5) begin errors++; $display("FAIL wrap_span got %0d want 5", e2 - e1); end
      if (d !== exp) begin errors++; $display("FAIL wrap_count got %h want %h", d, exp); end
   endtask

   task automatic test_strobe();
      logic [1:0]  r;
      logic [31:0] d;
      int e;
      axil_write(32'h0C, 32'hAABBCCDD, 4'hF, r, e);
      axil_write(32'h0C, 32'h11223344, 4'b1010, r, e);
      axil_read(32'h0C, d, r);
      checks++;
      if (d !== 32'h11BB33DD) begin errors++; $display("FAIL strb_cmp got %h want 11bb33dd", d); end
      axil_write(32'h00, 32'h0000FF5A, 4'b0010, r, e);
      checks++;
      if (gpio_out !== 8'hA5) begin errors++; $display("FAIL strb_gpio got %h want a5", gpio_out); end
      axil_write(32'h14, 32'hFFFFFFFF, 4'hF, r, e);
      axil_read(32'h14, d, r);
      checks++;
      if (d !== 32'h3) begin errors++; $display("FAIL strb_ctrl got %h want 3", d); end
      axil_write(32'h14, 32'h0, 4'hF, r, e);
   endtask

   task automatic test_decode_err();
      logic [1:0]  r;
      logic [31:0] d;
      int e;
      axil_write(32'h1C, 32'hFFFFFFFF, 4'hF, r, e);
      checks++;
      if (r !== 2'b10) begin errors++; $display("FAIL err_b_resp got %b want 10", r); end
      axil_read(32'h1C, d, r);
      checks += 2;
      if (r !== 2'b10) begin errors++; $display("FAIL err_r_resp got %b want 10", r); end
      if (d !== 32'h0) begin errors++; $display("FAIL err_r_data got %h want 0", d); end
      axil_read(32'h18, d, r);
      checks++;
      if (r !== 2'b10) begin errors++; $display("FAIL err18_r_resp got %b want 10", r); end
      axil_read(32'h0C, d, r);
      checks++;
      if (d !== 32'h11BB33DD) begin errors++; $display("FAIL err_cmp_kept got %h want 11bb33dd", d); end
      axil_write(32'h04, 32'hFFFFFFFF, 4'hF, r, e);
      checks += 2;
      if (r !== 2'b00) begin errors++; $display("FAIL gpioin_wr_resp got %b want 00", r); end
      if (gpio_out !== 8'hA5) begin errors++; $display("FAIL err_gpio_kept got %h want a5", gpio_out); end
   endtask

   task automatic test_gpio_in();
      logic [1:0]  r;
      logic [31:0] d;
      gpio_in = 8'h3C;
      tick(); tick();
      axil_read(32'h04, d, r);
      checks++;
      if (d !== 32'h0000003C) begin errors++; $display("FAIL gpio_in_read got %h want 0000003c", d); end
      gpio_in = 8'h00;
   endtask

   task automatic test_reset_mid();
      logic [1:0] r;
      int e;
      bus.b_ready = 1'b1;
      bus.w_data  = 32'h00000011;
      bus.w_strb  = 4'hF;
      bus.w_valid = 1'b1;
      tick();
      bus.w_valid  = 1'b0;
      bus.r_ready  = 1'b0;
      bus.ar_addr  = 32'h00;
      bus.ar_valid = 1'b1;
      tick();
      bus.ar_valid = 1'b0;
      tick();
      checks++;
      if (bus.r_valid !== 1'b1) begin errors++; $display("FAIL rmid_r_held got %b want 1", bus.r_valid); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks += 5;
      if (bus.r_valid !== 1'b0) begin errors++; $display("FAIL rmid_r_valid got %b want 0", bus.r_valid); end
      if (bus.ar_ready !== 1'b1) begin errors++; $display("FAIL rmid_ar_ready got %b want 1", bus.ar_ready); end
      if (bus.w_ready !== 1'b1) begin errors++; $display("FAIL rmid_w_ready got %b want 1", bus.w_ready); end
      if (bus.b_valid !== 1'b0) begin errors++; $display("FAIL rmid_b_valid got %b want 0", bus.b_valid); end
      if (gpio_out !== 8'h00) begin errors++; $display("FAIL rmid_gpio got %h want 00", gpio_out); end
      tick(); tick();
      checks += 2;
      if (bus.b_valid !== 1'b0) begin errors++; $display("FAIL rmid_stale_b got %b want 0", bus.b_valid); end
      if (bus.r_valid !== 1'b0) begin errors++; $display("FAIL rmid_stale_r got %b want 0", bus.r_valid); end
      axil_write(32'h00, 32'h00000022, 4'hF, r, e);
      checks += 2;
      if (r !== 2'b00) begin errors++; $display("FAIL rmid_new_resp got %b want 00", r); end
      if (gpio_out !== 8'h22) begin errors++; $display("FAIL rmid_new_gpio got %h want 22", gpio_out); end
   endtask

   initial begin
      bus.aw_addr  = '0;
      bus.aw_prot  = 3'b000;
      bus.aw_valid = 1'b0;
      bus.w_data   = '0;
      bus.w_strb   = '0;
      bus.w_valid  = 1'b0;
      bus.b_ready  = 1'b0;
      bus.ar_addr  = '0;
      bus.ar_prot  = 3'b000;
      bus.ar_valid = 1'b0;
      bus.r_ready  = 1'b0;
      test_reset();
      test_w_before_aw();
      test_timer_match();
      test_w1c();
      test_wrap();
      test_strobe();
      test_decode_err();
      test_gpio_in();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
